stream_protocol_checker: RTL
============================

STREAM_PROTOCOL_CHECKER -- requirements
Module: stream_protocol_checker

Interface
REQ-001 Parameters SHALL be, one per line:
  W, 8, data width in bits.
  TIMEOUT, 16, stall cycles allowed before a timeout error (range 1..255).
REQ-002 Ports SHALL be, one per line:
  clk  input  1  single clock; all logic on rising edge.
  rst  input  1  synchronous, active-high reset.
  clear  input  1  synchronous clear of errors, counters and checksum.
  data_i  input  W  observed stream data at the consumer end.
  valid_i  input  1  observed producer valid.
  ready_i  input  1  observed consumer ready.
  xfer_cnt_o  output  16  number of completed handshakes.
  checksum_o  output  8  modulo-256 sum of transferred data (low 8 bits when W>8).
  err_o  output  1  sticky protocol-violation flag.
  err_code_o  output  2  first violation code (00 none, 01 valid drop, 10 data change, 11 stall timeout).
REQ-003 The block SHALL be a passive monitor: it drives no handshake signal and has zero effect on the observed stream.

Function
REQ-004 Handshake SHALL mean valid_i=1 and ready_i=1 at a rising edge of clk.
REQ-005 The FSM SHALL have states IDLE, PENDING and ERROR.
REQ-006 IDLE -> PENDING SHALL occur when valid_i=1 and ready_i=0; data_i is captured into a hold register and the stall counter is set to 1.
REQ-007 IDLE SHALL remain IDLE on a handshake or when valid_i=0.
REQ-008 PENDING -> IDLE SHALL occur on a handshake with data_i equal to the held value.
REQ-009 PENDING with valid_i=0 SHALL go to ERROR with code 01.
REQ-010 PENDING with valid_i=1 and data_i different from the held value SHALL go to ERROR with code 10, whether or not ready_i=1.
REQ-011 PENDING with valid_i=1, ready_i=0 and unchanged data SHALL increment the stall counter; if the counter reaches TIMEOUT, the FSM SHALL go to ERROR with code 11.
REQ-012 Priority SHALL be code 01 > 10 > 11 when conditions coincide in one cycle.
REQ-013 ERROR SHALL be sticky: err_o=1 and err_code_o holds the first code until clear or rst; later violations are ignored.
REQ-014 err_o and err_code_o SHALL be registered, asserted the cycle after the violating edge.
REQ-015 Every handshake, in any state including ERROR, SHALL increment xfer_cnt_o; the counter saturates at 0xFFFF.
REQ-016 Every handshake SHALL add data_i[7:0] to checksum_o, with wrap-around mod 256.
REQ-017 Counters and checksum SHALL update one cycle after the handshake edge (registered).
REQ-018 clear SHALL force IDLE, err_o=0, err_code_o=00, xfer_cnt_o=0 and checksum_o=0, and SHALL take precedence over a same-cycle handshake or violation; that handshake is not counted.

Reset
REQ-019 rst SHALL have priority over clear and all other inputs.
REQ-020 On rst, all outputs and internal registers SHALL go to 0: state IDLE, xfer_cnt_o=0, checksum_o=0, err_o=0, err_code_o=00, stall counter 0, hold register 0.
REQ-021 rst asserted while in PENDING SHALL abandon the pending transfer without flagging an error.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
  Three back-to-back handshakes 0x10, 0x20, 0xF0 with ready_i=1 -> xfer_cnt_o=3, checksum_o=0x20, err_o=0.
  valid_i=1 with data 0x5A, ready_i=0 for 3 cycles, then ready_i=1 -> one transfer, err_o=0.
  valid_i=1 with data 0x5A stalled, data changes to 0x5B at cycle 2 -> err_o=1, err_code_o=10 next cycle.
  Stalled valid dropped to 0 before ready -> err_code_o=01; a following handshake still increments xfer_cnt_o.
  Stall held for TIMEOUT=16 cycles -> err_code_o=11 exactly at the 16th stall edge plus 1.
  clear coincident with a handshake -> xfer_cnt_o=0 and checksum_o=0; rst mid-PENDING -> all outputs 0 and no error.

Source files
------------

// File: rtl/stream_protocol_checker.sv
// stream_protocol_checker
//   Passive valid/ready stream monitor. It counts completed handshakes,
//   keeps a mod-256 checksum of the transferred data, and flags the first
//   protocol violation seen on a stalled transfer. The violations are a
//   valid drop, a data change, and a stall that lasts TIMEOUT cycles.
//   It drives no handshake signal.
//
// Parameters
//   W        data width in bits
//   TIMEOUT  stall cycles allowed before a timeout error (1..255)
//
// Ports
//   clk         clock; all logic acts on the rising edge
//   rst         synchronous active-high reset; has priority over everything
//   clear       synchronous clear of errors, counters and checksum
//   data_i      observed stream data
//   valid_i     observed producer valid
//   ready_i     observed consumer ready
//   xfer_cnt_o  completed handshakes; saturates at 0xFFFF
//   checksum_o  mod-256 sum of data_i[7:0] over all handshakes
//   err_o       sticky violation flag
//   err_code_o  first violation: 00 none, 01 valid drop, 10 data change,
//               11 stall timeout
module stream_protocol_checker #(
  parameter int W       = 8,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic [W-1:0] data_i,
  input  logic         valid_i,
  input  logic         ready_i,
  output logic [15:0]  xfer_cnt_o,
  output logic [7:0]   checksum_o,
  output logic         err_o,
  output logic [1:0]   err_code_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    ERROR   = 2'd2
  } state_t;

  localparam int XW = (W > 8) ? W : 8;

  state_t         state_q, state_d;
  logic [W-1:0]   hold_q, hold_d;
  logic [7:0]     stall_q, stall_d;
  logic [1:0]     code_q, code_d;
  logic           err_q;
  logic [15:0]    xfer_q;
  logic [7:0]     sum_q;
  logic [XW-1:0]  data_ext;
  logic [8:0]     stall_inc;
  logic           hs;

  assign hs        = valid_i & ready_i;
  assign stall_inc = {1'b0, stall_q} + 9'd1;

  // Zero-extend so the checksum can always take bits [7:0], even when W < 8.
  always_comb begin
    data_ext         = '0;
    data_ext[W-1:0]  = data_i;
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    stall_d = stall_q;
    code_d  = code_q;
    unique case (state_q)
      IDLE: begin
        if (valid_i && !ready_i) begin
          state_d = PENDING;
          hold_d  = data_i;
          stall_d = 8'd1;
        end
      end
      PENDING: begin
        // The order of these checks sets the error priority:
        // valid drop, then data change, then timeout.
        if (!valid_i) begin
          state_d = ERROR;
          code_d  = 2'b01;
        end else if (data_i != hold_q) begin
          state_d = ERROR;
          code_d  = 2'b10;
        end else if (ready_i) begin
          state_d = IDLE;
          stall_d = '0;
        end else if (stall_inc >= 9'(TIMEOUT)) begin
          state_d = ERROR;
          code_d  = 2'b11;
        end else begin
          stall_d = stall_inc[7:0];
        end
      end
      ERROR: begin
        state_d = ERROR;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      stall_q <= '0;
      code_q  <= '0;
      err_q   <= 1'b0;
      xfer_q  <= '0;
      sum_q   <= '0;
    end else if (clear) begin
      state_q <= IDLE;
      hold_q  <= '0;
      stall_q <= '0;
      code_q  <= '0;
      err_q   <= 1'b0;
      xfer_q  <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      stall_q <= stall_d;
      code_q  <= code_d;
      err_q   <= (state_d == ERROR);
      if (hs) begin
        if (xfer_q != 16'hFFFF) xfer_q <= xfer_q + 16'd1;
        sum_q <= sum_q + data_ext[7:0];
      end
    end
  end

  assign xfer_cnt_o = xfer_q;
  assign checksum_o = sum_q;
  assign err_o      = err_q;
  assign err_code_o = code_q;

endmodule
